// File: rtl/audio_level_meter.sv
// rtl/audio_level_meter.sv - windowed peak-amplitude level meter driving an LED bar/dot display
// Peak |sample - midscale| over WINDOW strobes becomes a 0..NUM_LEDS level with decaying peak hold.
module audio_level_meter #(
  parameter int SAMPLE_W     = 12,
  parameter int NUM_LEDS     = 9,
  parameter int WINDOW       = 4000,
  parameter int HOLD_WINDOWS = 5,
  parameter int LEVEL_W      = $clog2(NUM_LEDS + 1)
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                mode,
  input  logic                hold_en,
  output logic [NUM_LEDS-1:0] led,
  output logic [LEVEL_W-1:0]  level,
  output logic [LEVEL_W-1:0]  peak_level,
  output logic                window_done
);

  localparam int CNT_W  = $clog2(WINDOW);
  localparam int HOLD_W = $clog2(HOLD_WINDOWS + 1);
  localparam int PROD_W = SAMPLE_W + LEVEL_W;

  localparam logic [SAMPLE_W-1:0] MIDSCALE  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]    LAST      = CNT_W'(WINDOW - 1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(HOLD_WINDOWS);
  localparam logic [PROD_W-1:0]   LEDS_P    = PROD_W'(NUM_LEDS);
  localparam logic [LEVEL_W-1:0]  LEVEL_MAX = LEVEL_W'(NUM_LEDS);

  logic [CNT_W-1:0]    count;
  logic [SAMPLE_W-1:0] acc;
  logic [HOLD_W-1:0]   hold_cnt;

  logic [SAMPLE_W-1:0] amp;
  logic [SAMPLE_W-1:0] win_max;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   scaled;
  logic [LEVEL_W-1:0]  new_level;
  logic                window_end;

  logic [LEVEL_W-1:0]  level_nx;
  logic [LEVEL_W-1:0]  peak_nx;
  logic [HOLD_W-1:0]   hold_nx;
  logic [NUM_LEDS-1:0] led_nx;

  always_comb begin
    if (sample >= MIDSCALE) begin
      amp = sample - MIDSCALE;
    end else begin
      amp = MIDSCALE - sample;
    end
  end

  assign window_end = sample_valid && (count == LAST);
  assign win_max    = (amp > acc) ? amp : acc;

  // Full-width product then truncating shift: level = floor(max * NUM_LEDS / midscale).
  assign prod      = PROD_W'(win_max) * LEDS_P;
  assign scaled    = prod >> (SAMPLE_W - 1);
  assign new_level = (scaled > LEDS_P) ? LEVEL_MAX : scaled[LEVEL_W-1:0];

  always_comb begin
    level_nx = level;
    peak_nx  = peak_level;
    hold_nx  = hold_cnt;
    if (window_end) begin
      level_nx = new_level;
      if (new_level >= peak_level) begin
        peak_nx = new_level;
        hold_nx = HOLD_INIT;
      end else if (hold_cnt != '0) begin
        hold_nx = hold_cnt - HOLD_W'(1);
      end else begin
        // new_level < peak_level here, so one step down never undershoots it.
        peak_nx = peak_level - LEVEL_W'(1);
      end
    end
  end

  // LEDs are built from the next-state level/peak so they move on the same edge as level.
  always_comb begin
    led_nx = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (mode) begin
        led_nx[i] = (32'(level_nx) == i + 1);
      end else begin
        led_nx[i] = (32'(level_nx) > i);
      end
      if (hold_en && (32'(peak_nx) == i + 1)) begin
        led_nx[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      count       <= '0;
      acc         <= '0;
      hold_cnt    <= '0;
      level       <= '0;
      peak_level  <= '0;
      window_done <= 1'b0;
      led         <= '0;
    end else begin
      if (sample_valid) begin
        if (window_end) begin
          count <= '0;
          acc   <= '0;
        end else begin
          count <= count + CNT_W'(1);
          acc   <= win_max;
        end
      end
      level       <= level_nx;
      peak_level  <= peak_nx;
      hold_cnt    <= hold_nx;
      window_done <= window_end;
      led         <= led_nx;
    end
  end

endmodule

// File: tb/tb_audio_level_meter.sv
// tb/tb_audio_level_meter.sv - directed and randomized checks of audio_level_meter against a window model
module tb_audio_level_meter;

  localparam int SW   = 12;
  localparam int NL   = 9;
  localparam int WIN  = 4;
  localparam int HOLD = 5;
  localparam int LW   = $clog2(NL + 1);
  localparam int MID  = 2048;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic [SW-1:0] sample;
  logic          mode;
  logic          hold_en;
  logic [NL-1:0] led;
  logic [LW-1:0] level;
  logic [LW-1:0] peak_level;
  logic          window_done;

  int checks   = 0;
  int failures = 0;

  // Window model: samples collected so far, plus level/peak state.
  int win_amps[$];
  int m_level, m_peak, m_hold;
  bit m_done;

  audio_level_meter #(
    .SAMPLE_W(SW), .NUM_LEDS(NL), .WINDOW(WIN), .HOLD_WINDOWS(HOLD)
  ) dut (
    .clock(clock), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
    .mode(mode), .hold_en(hold_en), .led(led), .level(level),
    .peak_level(peak_level), .window_done(window_done)
  );

  always #5 clock = ~clock;

  function automatic int amp_of(int s);
    return (s >= MID) ? s - MID : MID - s;
  endfunction

  function automatic int exp_led(int lv, int pk, bit md, bit he);
    int r;
    if (md) r = (lv > 0) ? (1 << (lv - 1)) : 0;
    else    r = (1 << lv) - 1;
    if (he && pk > 0) r = r | (1 << (pk - 1));
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(bit rst, bit valid, int s);
    int mx, lv;
    m_done = 1'b0;
    if (rst) begin
      win_amps.delete();
      m_level = 0; m_peak = 0; m_hold = 0;
    end else if (valid) begin
      win_amps.push_back(amp_of(s));
      if (win_amps.size() == WIN) begin
        mx = 0;
        foreach (win_amps[k]) if (win_amps[k] > mx) mx = win_amps[k];
        lv = (mx * NL) / MID;
        if (lv > NL) lv = NL;
        m_level = lv;
        if (lv >= m_peak) begin
          m_peak = lv; m_hold = HOLD;
        end else if (m_hold > 0) begin
          m_hold--;
        end else begin
          m_peak--;
        end
        m_done = 1'b1;
        win_amps.delete();
      end
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".level"}, 32'(level), m_level);
    chk({tag, ".peak"}, 32'(peak_level), m_peak);
    chk({tag, ".done"}, 32'(window_done), 32'(m_done));
    chk({tag, ".led"}, 32'(led), exp_led(m_level, m_peak, mode, hold_en));
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, check at the next negedge.
  task automatic step(bit valid, int s, string tag);
    sample_valid = valid;
    sample       = SW'(s);
    @(posedge clock);
    model_edge(!rst_n, valid, s);
    @(negedge clock);
    check_outputs(tag);
  endtask

  task automatic push(int s, int gap, string tag);
    step(1'b1, s, tag);
    for (int g = 0; g < gap; g++) step(1'b0, 0, tag);
  endtask

  task automatic run_window(int s0, int s1, int s2, int s3, int gap, string tag);
    push(s0, gap, tag);
    push(s1, gap, tag);
    push(s2, gap, tag);
    push(s3, gap, tag);
    step(1'b0, 0, {tag, ".after"});
  endtask

  int exp_pk[8];

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sample = '0; mode = 1'b0; hold_en = 1'b0;
    m_level = 0; m_peak = 0; m_hold = 0; m_done = 1'b0;
    @(negedge clock);

    // Reset held three cycles, then 20 quiet cycles.
    for (int k = 0; k < 3; k++) step(1'b0, 0, "s1_reset");
    chk("s1_led_zero", 32'(led), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) step(1'b0, 0, "s1_idle");

    // Silence then full scale with the final sample carrying the peak.
    run_window(2048, 2048, 2048, 2048, 0, "s2_silence");
    chk("s2_silence_level", 32'(level), 0);
    push(2048, 0, "s2_full"); push(2048, 0, "s2_full"); push(2048, 0, "s2_full");
    push(0, 0, "s2_full_last");
    chk("s2_done_pulse", 32'(window_done), 1);
    chk("s2_level9", 32'(level), 9);
    chk("s2_led_bar", 32'(led), 32'h1FF);
    step(1'b0, 0, "s2_after");
    chk("s2_done_drop", 32'(window_done), 0);

    // Truncation of the scaled amplitude.
    run_window(2048, 3072, 2100, 2048, 0, "s3_amp1024");
    chk("s3_level4", 32'(level), 4);
    chk("s3_led4", 32'(led), 32'h00F);
    run_window(2048, 1, 2048, 2048, 0, "s3_amp2047");
    chk("s3_level8", 32'(level), 8);
    mode = 1'b1;
    run_window(3072, 2048, 2048, 2048, 0, "s3_dot");
    chk("s3_dot_led", 32'(led), 32'h008);
    mode = 1'b0;
    step(1'b0, 0, "s3_mode_back");

    // Peak hold and decay after a clean reset.
    rst_n = 1'b0; step(1'b0, 0, "s4_reset"); rst_n = 1'b1;
    run_window(2048, 2048, 2048, 0, 0, "s4_loud");
    chk("s4_peak_init", 32'(peak_level), 9);
    exp_pk = '{9, 9, 9, 9, 9, 8, 7, 6};
    for (int w = 0; w < 8; w++) begin
      run_window(2048, 2048, 2048, 2048, 0, "s4_quiet");
      chk("s4_peak_seq", 32'(peak_level), exp_pk[w]);
      if (w == 6) begin
        hold_en = 1'b1;
        step(1'b0, 0, "s4_hold_on");
        chk("s4_hold_led", 32'(led), 32'h040);
      end
    end
    hold_en = 1'b0;

    // Reset in the middle of a window discards it.
    push(0, 0, "s5_pre"); push(0, 0, "s5_pre");
    rst_n = 1'b0; step(1'b0, 0, "s5_reset"); rst_n = 1'b1;
    run_window(2048, 2048, 2048, 2048, 0, "s5_post");
    chk("s5_level", 32'(level), 0);
    chk("s5_peak", 32'(peak_level), 0);

    // Strobes every fifth cycle.
    run_window(2048, 2048, 2048, 2048, 4, "s6_silence");
    run_window(2048, 2048, 2048, 0, 4, "s6_full");
    chk("s6_peak9", 32'(peak_level), 9);

    // Randomized windows, gaps and display settings.
    for (int w = 0; w < 40; w++) begin
      int kind;
      int s[4];
      kind = int'($urandom_range(0, 2));
      for (int k = 0; k < 4; k++) begin
        if (kind == 0) s[k] = 2048 + int'($urandom_range(0, 200)) - 100;
        else           s[k] = int'($urandom_range(0, 4095));
      end
      mode    = 1'($urandom_range(0, 1));
      hold_en = 1'($urandom_range(0, 1));
      run_window(s[0], s[1], s[2], s[3], int'($urandom_range(0, 3)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
